// File: rtl/cv_tilemap_scan_if.sv
// Tile RAM read port (port1) as seen by the scan-out stage.
// The scanner drives the address side; the RAM returns registered read data.
interface cv_tilemap_scan_if #(
    parameter int A_WIDTH = 10
);
    logic [A_WIDTH-1:0] ram_addr;
    logic               ram_en;
    logic [1:0]         ram_we;
    logic [9:0]         ram_wrdata;
    logic [9:0]         ram_rddata;

    modport master (
        output ram_addr, ram_en, ram_we, ram_wrdata,
        input  ram_rddata
    );

    modport slave (
        input  ram_addr, ram_en, ram_we, ram_wrdata,
        output ram_rddata
    );
endinterface

// File: rtl/cv_tilemap_scan.sv
// Tile-map scan-out: raster counters, frame-latched scroll, tile RAM addressing
// and a two-stage pipeline that hides the RAM's registered read latency.
module cv_tilemap_scan #(
    parameter int A_WIDTH      = 10,
    parameter int H_ACTIVE     = 256,
    parameter int H_TOTAL      = 320,
    parameter int H_SYNC_START = 272,
    parameter int H_SYNC_LEN   = 24,
    parameter int V_ACTIVE     = 224,
    parameter int V_TOTAL      = 262,
    parameter int V_SYNC_START = 234,
    parameter int V_SYNC_LEN   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pix_ce,
    input  logic [7:0]              scroll_x,
    input  logic [7:0]              scroll_y,
    cv_tilemap_scan_if.master       ram,
    output logic [9:0]              tile_code,
    output logic [2:0]              tile_px,
    output logic [2:0]              tile_py,
    output logic                    de,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    frame_start
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic [7:0]    sx, sy;
    logic [31:0]   h_w, v_w;
    logic          h_last, v_last;
    logic          active, hs, vs, first;
    logic [7:0]    x_pos, y_pos;
    logic [9:0]    addr_full;

    logic          s1_active, s1_hs, s1_vs, s1_first;
    logic [2:0]    s1_px, s1_py;

    assign h_w    = 32'(hcount);
    assign v_w    = 32'(vcount);
    assign h_last = (h_w == 32'(H_TOTAL - 1));
    assign v_last = (v_w == 32'(V_TOTAL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                hcount <= '0;
                if (v_last) vcount <= '0;
                else        vcount <= vcount + VW'(1);
            end else begin
                hcount <= hcount + HW'(1);
            end
        end
    end

    // Scroll only changes across the frame boundary so a frame never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx <= '0;
            sy <= '0;
        end else if (pix_ce && h_last && v_last) begin
            sx <= scroll_x;
            sy <= scroll_y;
        end
    end

    assign active = (h_w < 32'(H_ACTIVE)) && (v_w < 32'(V_ACTIVE));
    assign hs     = (h_w >= 32'(H_SYNC_START)) && (h_w < 32'(H_SYNC_START + H_SYNC_LEN));
    assign vs     = (v_w >= 32'(V_SYNC_START)) && (v_w < 32'(V_SYNC_START + V_SYNC_LEN));
    assign first  = (hcount == '0) && (vcount == '0);

    assign x_pos     = 8'(hcount) + sx;
    assign y_pos     = 8'(vcount) + sy;
    assign addr_full = {y_pos[7:3], x_pos[7:3]};

    assign ram.ram_addr   = A_WIDTH'(addr_full);
    assign ram.ram_en     = pix_ce & active & ~rst;
    assign ram.ram_we     = '0;
    assign ram.ram_wrdata = '0;

    // Stage 1 travels alongside the RAM read; stage 2 meets the returned data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_active   <= 1'b0;
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
            s1_first    <= 1'b0;
            s1_px       <= '0;
            s1_py       <= '0;
            tile_code   <= '0;
            tile_px     <= '0;
            tile_py     <= '0;
            de          <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce & s1_first;
            if (pix_ce) begin
                s1_active <= active;
                s1_hs     <= hs;
                s1_vs     <= vs;
                s1_first  <= first;
                s1_px     <= x_pos[2:0];
                s1_py     <= y_pos[2:0];
                tile_code <= s1_active ? ram.ram_rddata : '0;
                tile_px   <= s1_px;
                tile_py   <= s1_py;
                de        <= s1_active;
                hsync     <= s1_hs;
                vsync     <= s1_vs;
            end
        end
    end
endmodule

// File: tb/tb_cv_tilemap_scan.sv
// Self-checking bench for cv_tilemap_scan on a reduced raster so whole frames fit
// in a short run; a position-based reference model predicts every output.
module tb_cv_tilemap_scan;
    localparam int HA  = 16;
    localparam int HT  = 24;
    localparam int HSS = 18;
    localparam int HSL = 3;
    localparam int VA  = 10;
    localparam int VT  = 14;
    localparam int VSS = 11;
    localparam int VSL = 2;
    localparam int F   = HT * VT;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_ce;
    logic [7:0] scroll_x, scroll_y;
    logic [9:0] tile_code;
    logic [2:0] tile_px, tile_py;
    logic       de, hsync, vsync, frame_start;

    logic [9:0] mem [1024];

    cv_tilemap_scan_if #(.A_WIDTH(10)) ram_bus ();

    cv_tilemap_scan #(
        .A_WIDTH(10), .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
        .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .scroll_x(scroll_x), .scroll_y(scroll_y),
        .ram(ram_bus.master), .tile_code(tile_code), .tile_px(tile_px), .tile_py(tile_py),
        .de(de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_bus.ram_en) ram_bus.ram_rddata <= mem[ram_bus.ram_addr];

    typedef struct {
        logic       act, hs, vs, first;
        logic [9:0] code;
        logic [2:0] px, py;
    } pix_t;

    typedef struct {
        int         tick;
        logic       de, fs, hs;
        logic [9:0] code;
        logic [2:0] px;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   pos, msx, msy, clk_idx;
    pix_t pq[$];
    pix_t exp_out, zero_pix;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic pix_t ref_pix(input int k, input int sxv, input int syv);
        pix_t r;
        int p, h, v, x, y;
        p = k % F; h = p % HT; v = p / HT;
        x = (h + sxv) % 256; y = (v + syv) % 256;
        r.act   = (h < HA) && (v < VA);
        r.hs    = (h >= HSS) && (h < HSS + HSL);
        r.vs    = (v >= VSS) && (v < VSS + VSL);
        r.first = (p == 0);
        r.code  = r.act ? mem[(y / 8) * 32 + x / 8] : 10'd0;
        r.px    = 3'(x % 8);
        r.py    = 3'(y % 8);
        return r;
    endfunction

    function automatic int ref_addr(input int k, input int sxv, input int syv);
        int p;
        p = k % F;
        return (((p / HT + syv) % 256) / 8) * 32 + ((p % HT + sxv) % 256) / 8;
    endfunction

    task automatic model_reset();
        pos = 0; msx = 0; msy = 0;
        pq.delete();
        exp_out = zero_pix;
    endtask

    task automatic model_edge();
        pix_t rec;
        rec = ref_pix(pos, msx, msy);
        if (pos % F == F - 1) begin
            msx = int'(scroll_x);
            msy = int'(scroll_y);
        end
        pos++;
        pq.push_back(rec);
        if (pq.size() > 2) void'(pq.pop_front());
        exp_out = (pq.size() == 2) ? pq[0] : zero_pix;
    endtask

    task automatic step(input bit ce);
        pix_t cur;
        bit   exp_fs;
        pix_ce = ce;
        @(posedge clk);
        clk_idx++;
        if (ce) model_edge();
        exp_fs = ce && exp_out.first;
        @(negedge clk);
        cur = ref_pix(pos, msx, msy);
        chk("de",          32'(de),          32'(exp_out.act));
        chk("hsync",       32'(hsync),       32'(exp_out.hs));
        chk("vsync",       32'(vsync),       32'(exp_out.vs));
        chk("tile_code",   32'(tile_code),   32'(exp_out.code));
        chk("tile_px",     32'(tile_px),     32'(exp_out.px));
        chk("tile_py",     32'(tile_py),     32'(exp_out.py));
        chk("frame_start", 32'(frame_start), 32'(exp_fs));
        chk("ram_addr",    32'(ram_bus.ram_addr), 32'(ref_addr(pos, msx, msy)));
        chk("ram_en",      32'(ram_bus.ram_en),   32'(pix_ce && cur.act));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_de"},    32'(de),          32'd0);
        chk({tag, "_hs"},    32'(hsync),       32'd0);
        chk({tag, "_vs"},    32'(vsync),       32'd0);
        chk({tag, "_code"},  32'(tile_code),   32'd0);
        chk({tag, "_px"},    32'(tile_px),     32'd0);
        chk({tag, "_py"},    32'(tile_py),     32'd0);
        chk({tag, "_fs"},    32'(frame_start), 32'd0);
        chk({tag, "_en"},    32'(ram_bus.ram_en), 32'd0);
    endtask

    // Called just after a negedge: reset lands between clock edges.
    task automatic apply_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_zero(tag);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_fs(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1'b1);
            if (frame_start) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        int last_fs, ticks, nt;
        bit ce;

        vecs = '{
            '{1,  1'b0, 1'b0, 1'b0, 10'h000, 3'd0},
            '{2,  1'b1, 1'b1, 1'b0, 10'h155, 3'd0},
            '{3,  1'b1, 1'b0, 1'b0, 10'h155, 3'd1},
            '{9,  1'b1, 1'b0, 1'b0, 10'h155, 3'd7},
            '{10, 1'b1, 1'b0, 1'b0, 10'h2AA, 3'd0},
            '{17, 1'b1, 1'b0, 1'b0, 10'h2AA, 3'd7},
            '{18, 1'b0, 1'b0, 1'b0, 10'h000, 3'd0},
            '{19, 1'b0, 1'b0, 1'b0, 10'h000, 3'd1},
            '{20, 1'b0, 1'b0, 1'b1, 10'h000, 3'd2},
            '{22, 1'b0, 1'b0, 1'b1, 10'h000, 3'd4},
            '{23, 1'b0, 1'b0, 1'b0, 10'h000, 3'd5}
        };

        for (int i = 0; i < 1024; i++) mem[i] = 10'($urandom);
        mem[0] = 10'h155;
        mem[1] = 10'h2AA;
        zero_pix = '{act: 1'b0, hs: 1'b0, vs: 1'b0, first: 1'b0, code: 10'd0, px: 3'd0, py: 3'd0};
        clk_idx  = 0;
        rst = 1'b1; pix_ce = 1'b0; scroll_x = 8'd0; scroll_y = 8'd0;
        ram_bus.ram_rddata = 10'd0;
        model_reset();

        @(negedge clk);
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // First line at full rate against hand-computed vectors.
        for (int n = 1; n <= 24; n++) begin
            step(1'b1);
            foreach (vecs[j]) if (vecs[j].tick == n) begin
                chk("vec_de",   32'(de),          32'(vecs[j].de));
                chk("vec_fs",   32'(frame_start), 32'(vecs[j].fs));
                chk("vec_hs",   32'(hsync),       32'(vecs[j].hs));
                chk("vec_code", 32'(tile_code),   32'(vecs[j].code));
                chk("vec_px",   32'(tile_px),     32'(vecs[j].px));
            end
        end

        // Mid-frame scroll change takes effect only at the next frame.
        while (pos % F != 100) step(1'b1);
        scroll_x = 8'd4; scroll_y = 8'd9;
        wait_fs("scroll_fs_seen", 2 * F);
        chk("scroll_px0",   32'(tile_px),   32'd4);
        chk("scroll_py0",   32'(tile_py),   32'd1);
        chk("scroll_code0", 32'(tile_code), 32'(mem[32]));
        for (int i = 0; i < 4; i++) step(1'b1);
        chk("scroll_px4",   32'(tile_px),   32'd0);
        chk("scroll_code4", 32'(tile_code), 32'(mem[33]));

        // X wrap at 255 -> 0.
        for (int i = 0; i < 50; i++) step(1'b1);
        scroll_x = 8'd250; scroll_y = 8'd0;
        wait_fs("wrap_fs_seen", 2 * F);
        chk("wrap_px0",   32'(tile_px),   32'd2);
        chk("wrap_code0", 32'(tile_code), 32'(mem[31]));
        for (int i = 0; i < 6; i++) step(1'b1);
        chk("wrap_px6",   32'(tile_px),   32'd0);
        chk("wrap_code6", 32'(tile_code), 32'(mem[0]));

        // pix_ce every third clock, random scroll; measure frame period.
        last_fs = -1; ticks = 0;
        for (int i = 0; i < 3 * F * 3; i++) begin
            ce = (clk_idx % 3 == 0);
            if ($urandom_range(0, 199) == 0) begin
                scroll_x = 8'($urandom); scroll_y = 8'($urandom);
            end
            step(ce);
            if (ce) ticks++;
            if (frame_start) begin
                if (last_fs >= 0) chk("frame_period", 32'(ticks - last_fs), 32'(F));
                last_fs = ticks;
            end
        end
        chk("slow_fs_seen", 32'(last_fs >= 0), 32'd1);

        // Random pix_ce, then reset asynchronously at line 5 pixel 10.
        for (int i = 0; i < 2 * F; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                scroll_x = 8'($urandom); scroll_y = 8'($urandom);
            end
            step(1'($urandom_range(0, 1)));
        end
        nt = 0;
        while (pos % F != 5 * HT + 10 && nt < 4 * F) begin
            step(1'($urandom_range(0, 1)));
            nt++;
        end
        chk("reach_line5", 32'(pos % F), 32'(5 * HT + 10));
        apply_reset("midreset");
        nt = 0;
        for (int i = 0; i < 10 && !frame_start; i++) begin
            step(1'b1);
            nt++;
        end
        chk("fs_after_reset", 32'(nt), 32'd2);
        for (int i = 0; i < F + 50; i++) step(1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cv_tilemap_scan.md
Name: cv_tilemap_scan

Overview:
- Video scan-out stage that reads the 10-bit dual-port tile RAM's read-only port (port1) and produces a pixel-aligned tile-code stream.
- The CPU side writes the RAM through port0.
- Generates horizontal/vertical raster timing, computes tile-map addresses with frame-latched scroll, and absorbs the RAM's 1-cycle registered read latency.
- Feeds the downstream pattern/palette lookup.

Parameters:
- A_WIDTH, 10, tile RAM address width; map is 2**(A_WIDTH/2) columns by 2**(A_WIDTH/2) rows.
- H_ACTIVE, 256, visible pixels per line.
- H_TOTAL, 320, pixels per line including blanking.
- H_SYNC_START, 272, hcount at which hsync asserts.
- H_SYNC_LEN, 24, hsync width in pixels.
- V_ACTIVE, 224, visible lines per frame.
- V_TOTAL, 262, lines per frame.
- V_SYNC_START, 234, vcount at which vsync asserts.
- V_SYNC_LEN, 3, vsync width in lines.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- pix_ce  in  1  pixel clock enable; all raster state advances only when high.
- scroll_x  in  8  horizontal scroll in pixels, latched at frame start.
- scroll_y  in  8  vertical scroll in pixels, latched at frame start.
- ram_addr  out  A_WIDTH  address to tile RAM port1.
- ram_en  out  1  enable to tile RAM port1.
- ram_we  out  2  write enable to tile RAM port1; constant 0.
- ram_wrdata  out  10  constant 0.
- ram_rddata  in  10  registered read data from tile RAM port1.
- tile_code  out  10  tile entry for current output pixel; 0 when de=0.
- tile_px  out  3  pixel column within the tile (0..7).
- tile_py  out  3  pixel row within the tile (0..7).
- de  out  1  display enable, aligned with tile_code.
- hsync  out  1  horizontal sync, active-high, aligned with de.
- vsync  out  1  vertical sync, active-high, aligned with de.
- frame_start  out  1  one-clk pulse on the pix_ce that outputs pixel (0,0).

Behaviour:
- Reset (async, rst=1): hcount=0, vcount=0, sx/sy latches=0, all pipeline registers and all outputs 0.
- Clock/reset domain: single clk domain with rst asynchronous and active-high.
- Counters advance on each pix_ce:
  - hcount wraps from H_TOTAL-1 to 0, incrementing vcount.
  - vcount wraps from V_TOTAL-1 to 0.
  - No change when pix_ce=0.
- Scroll latch: sx<=scroll_x and sy<=scroll_y on the pix_ce where hcount=H_TOTAL-1 and vcount=V_TOTAL-1. Mid-frame scroll changes have no effect until the next frame.
- Timing flags:
  - active = (hcount<H_ACTIVE) and (vcount<V_ACTIVE).
  - hs = hcount in [H_SYNC_START, H_SYNC_START+H_SYNC_LEN).
  - vs is defined likewise on vcount.
- Address generation (combinational from counters):
  - X = (hcount+sx) mod 256, Y = (vcount+sy) mod 256, 8-bit wrap.
  - ram_addr = {Y[7:3], X[7:3]} truncated to A_WIDTH (row-major, 32 columns at default).
  - ram_en = pix_ce and active.
- Stage 1 (on pix_ce): register active, hs, vs, X[2:0], Y[2:0], first = (hcount==0 and vcount==0). The RAM captures mem[ram_addr] on the same edge.
- Stage 2 (on pix_ce):
  - tile_code <= ram_rddata if stage1 active, else 0.
  - tile_px, tile_py, de, hsync, vsync <= stage1 values.
- Latency: outputs reflect raster position (h,v) exactly 2 pix_ce ticks after the counters held (h,v). Outputs hold between pix_ce pulses.
- frame_start: 1 for exactly one clk, on the clk where stage 2 loads with stage1 first=1. Otherwise 0, even if pix_ce stays low afterwards.
- Stale RAM data: RAM data is never consumed when ram_en was low (blanking); de=0 forces tile_code=0.
- pix_ce=1 every clk: full-rate, same 2-clk latency.
- Reset mid-frame: everything returns to the reset state immediately. The first output pixel after release is (0,0) with scroll 0, and frame_start fires 2 pix_ce ticks after release.

Test Plan:
- Reset, pix_ce=1 constant, scroll 0, RAM[0]=10'h155, RAM[1]=10'h2AA.
  - Expect frame_start and de rise 2 clks after the first counted pixel.
  - tile_code=0x155 for px 0..7, then 0x2AA with tile_px 0..7.
- Line timing over one line:
  - de high 256 pixels, hsync high at output pixel 272..295.
  - Line period 320; vsync high for lines 234..236; frame 83840 pix_ce ticks.
- scroll_x=4, scroll_y=9 applied mid-frame:
  - Unchanged until the next frame_start.
  - Then first pixel reads ram_addr 1*32+0 with tile_px=4, tile_py=1; tile boundary after 4 pixels.
- Wrap: scroll_x=250 -> output pixel 6 reads column 0 (X wraps 255->0); ram_addr never exceeds 1023.
- pix_ce every 3rd clk: outputs change only after pix_ce edges, values identical to the full-rate run; frame_start stays 1 clk wide.
- Assert rst at line 100 pixel 50:
  - All outputs 0 asynchronously.
  - After release, re-synchronises to (0,0) and frame_start fires after 2 pix_ce.
